// File: rtl/pipelined_control_unit.sv
// Control path for a 5-stage MIPS pipeline: ID-stage decode, load-use stall,
// branch flush, and ID/EX -> EX/MEM -> MEM/WB control registers.
module pipelined_control_unit #(
    parameter int OPCODE_W   = 6,
    parameter int ALUOP_W    = 3,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   OpCode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  flush,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_Jump,
    output logic [1:0]            ex_RegDst,
    output logic                  ex_ALUSrc,
    output logic [ALUOP_W-1:0]    ex_ALUOp,
    output logic                  ex_MemRead,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic                  mem_Branch,
    output logic                  mem_BranchNE,
    output logic                  wb_RegWrite,
    output logic [1:0]            wb_MemtoReg
);

    typedef struct packed {
        logic [1:0]         reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               branch_ne;
        logic               reg_write;
        logic [1:0]         mem_to_reg;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);

    // The link register must be addressable; ALUOp needs room for six classes.
    if (ALUOP_W < 3) begin : g_aluop_chk
        $error("ALUOP_W must be >= 3");
    end
    if (LINK_REG >= (1 << REG_ADDR_W)) begin : g_link_chk
        $error("LINK_REG does not fit in REG_ADDR_W");
    end

    ctrl_t dec_s;
    logic  jump_s;
    logic  stall_s;
    ctrl_t id_ex_r;
    ctrl_t ex_mem_r;
    ctrl_t mem_wb_r;

    // ID-stage opcode decode into a control bundle plus the jump redirect.
    always_comb begin
        dec_s  = BUBBLE;
        jump_s = 1'b0;
        case (OpCode)
            OP_RTYPE: begin
                dec_s.reg_dst   = 2'b01;
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = ALUOP_W'(3'b010);
            end
            OP_LW: begin
                dec_s.alu_src    = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.mem_to_reg = 2'b01;
            end
            OP_SW: begin
                dec_s.alu_src   = 1'b1;
                dec_s.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_s.branch = 1'b1;
                dec_s.alu_op = ALUOP_W'(3'b001);
            end
            OP_BNE: begin
                dec_s.branch_ne = 1'b1;
                dec_s.alu_op    = ALUOP_W'(3'b001);
            end
            OP_ADDI: begin
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = ALUOP_W'(3'b011);
            end
            OP_ORI: begin
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = ALUOP_W'(3'b100);
            end
            OP_SLTI: begin
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = ALUOP_W'(3'b101);
            end
            OP_J: begin
                jump_s = 1'b1;
            end
            OP_JAL: begin
                jump_s           = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.reg_dst    = 2'b10;
                dec_s.mem_to_reg = 2'b10;
            end
            default: begin
                dec_s  = BUBBLE;
                jump_s = 1'b0;
            end
        endcase
    end

    // Load-use hazard: both sources compared regardless of opcode.
    always_comb begin
        stall_s     = id_ex_r.mem_read & (ex_rt != {REG_ADDR_W{1'b0}}) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));
        pc_write    = ~stall_s | flush;
        if_id_write = ~stall_s | flush;
        id_Jump     = jump_s & ~stall_s & ~flush;
    end

    // Pipeline control registers; flush kills ID and EX, MEM always completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_r  <= BUBBLE;
            ex_mem_r <= BUBBLE;
            mem_wb_r <= BUBBLE;
        end else begin
            id_ex_r  <= (stall_s | flush) ? BUBBLE : dec_s;
            ex_mem_r <= flush ? BUBBLE : id_ex_r;
            mem_wb_r <= ex_mem_r;
        end
    end

    assign ex_RegDst    = id_ex_r.reg_dst;
    assign ex_ALUSrc    = id_ex_r.alu_src;
    assign ex_ALUOp     = id_ex_r.alu_op;
    assign ex_MemRead   = id_ex_r.mem_read;
    assign mem_MemRead  = ex_mem_r.mem_read;
    assign mem_MemWrite = ex_mem_r.mem_write;
    assign mem_Branch   = ex_mem_r.branch;
    assign mem_BranchNE = ex_mem_r.branch_ne;
    assign wb_RegWrite  = mem_wb_r.reg_write;
    assign wb_MemtoReg  = mem_wb_r.mem_to_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: reset, decode latency, load-use
// stall, flush, jal and asynchronous reset, with hand-computed expectations.
module tb_pipelined_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] OpCode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rt;
    logic       flush;
    logic       pc_write;
    logic       if_id_write;
    logic       id_Jump;
    logic [1:0] ex_RegDst;
    logic       ex_ALUSrc;
    logic [2:0] ex_ALUOp;
    logic       ex_MemRead;
    logic       mem_MemRead;
    logic       mem_MemWrite;
    logic       mem_Branch;
    logic       mem_BranchNE;
    logic       wb_RegWrite;
    logic [1:0] wb_MemtoReg;

    int checks;
    int failures;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rt(ex_rt), .flush(flush), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_Jump(id_Jump), .ex_RegDst(ex_RegDst),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_MemRead(ex_MemRead),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_Branch(mem_Branch), .mem_BranchNE(mem_BranchNE),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        OpCode   = 6'b000000;
        id_rs    = 5'd0;
        id_rt    = 5'd0;
        ex_rt    = 5'd0;
        flush    = 1'b0;
        step();
        step();
        check("rst_ex_regdst",  {30'd0, ex_RegDst},   32'd0);
        check("rst_ex_aluop",   {29'd0, ex_ALUOp},    32'd0);
        check("rst_mem_memrd",  {31'd0, mem_MemRead}, 32'd0);
        check("rst_wb_regwr",   {31'd0, wb_RegWrite}, 32'd0);
        check("rst_wb_memtoreg",{30'd0, wb_MemtoReg}, 32'd0);
        check("rst_pc_write",   {31'd0, pc_write},    32'd1);
        check("rst_if_id_write",{31'd0, if_id_write}, 32'd1);

        // Release reset: R-type flows through.
        rst = 1'b1;
        step();
        check("rel_ex_regdst", {30'd0, ex_RegDst},   32'd1);
        check("rel_ex_aluop",  {29'd0, ex_ALUOp},    32'd2);
        check("rel_wb_early",  {31'd0, wb_RegWrite}, 32'd0);
        step();
        step();
        check("rel_wb_regwr",  {31'd0, wb_RegWrite}, 32'd1);

        // lw rt=5 followed by add using rs=5 -> one stall cycle.
        OpCode = 6'b100011; id_rt = 5'd5; id_rs = 5'd0;
        step();
        check("lw_ex_memrd",  {31'd0, ex_MemRead}, 32'd1);
        check("lw_ex_alusrc", {31'd0, ex_ALUSrc},  32'd1);
        ex_rt = 5'd5; OpCode = 6'b000000; id_rs = 5'd5; id_rt = 5'd6;
        #1;
        check("lu_pc_write",    {31'd0, pc_write},    32'd0);
        check("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
        step();
        check("lu_bub_regdst", {30'd0, ex_RegDst},   32'd0);
        check("lu_bub_aluop",  {29'd0, ex_ALUOp},    32'd0);
        check("lu_bub_memrd",  {31'd0, ex_MemRead},  32'd0);
        check("lu_mem_memrd",  {31'd0, mem_MemRead}, 32'd1);
        check("lu_no_repeat",  {31'd0, pc_write},    32'd1);
        step();
        check("lu_add_regdst", {30'd0, ex_RegDst},   32'd1);
        check("lu_add_aluop",  {29'd0, ex_ALUOp},    32'd2);
        check("lu_wb_lw_regwr",{31'd0, wb_RegWrite}, 32'd1);
        check("lu_wb_lw_mtr",  {30'd0, wb_MemtoReg}, 32'd1);

        // lw with rt=0 matching rs=0 -> no stall.
        OpCode = 6'b100011; id_rt = 5'd0; id_rs = 5'd0;
        step();
        ex_rt = 5'd0; OpCode = 6'b000000;
        #1;
        check("r0_pc_write", {31'd0, pc_write}, 32'd1);
        step();
        check("r0_ex_regdst", {30'd0, ex_RegDst}, 32'd1);

        // beq -> addi -> lw, flush while beq in MEM.
        OpCode = 6'b000100; id_rs = 5'd1; id_rt = 5'd1; ex_rt = 5'd2;
        step();
        check("beq_ex_aluop", {29'd0, ex_ALUOp}, 32'd1);
        OpCode = 6'b001000;
        step();
        OpCode = 6'b100011;
        flush  = 1'b1;
        #1;
        check("fl_mem_branch",  {31'd0, mem_Branch}, 32'd1);
        check("fl_pc_write",    {31'd0, pc_write},   32'd1);
        step();
        flush = 1'b0;
        check("fl_ex_alusrc",   {31'd0, ex_ALUSrc},   32'd0);
        check("fl_ex_memrd",    {31'd0, ex_MemRead},  32'd0);
        check("fl_ex_aluop",    {29'd0, ex_ALUOp},    32'd0);
        check("fl_mem_memrd",   {31'd0, mem_MemRead}, 32'd0);
        check("fl_mem_branch0", {31'd0, mem_Branch},  32'd0);
        check("fl_wb_regwr",    {31'd0, wb_RegWrite}, 32'd0);

        // Stall with jal in ID, then stall plus flush.
        OpCode = 6'b100011; id_rt = 5'd7; id_rs = 5'd0;
        step();
        ex_rt = 5'd7; id_rs = 5'd7; OpCode = 6'b000011;
        #1;
        check("st_pc_write", {31'd0, pc_write}, 32'd0);
        check("st_id_jump",  {31'd0, id_Jump},  32'd0);
        flush = 1'b1;
        #1;
        check("sf_pc_write",    {31'd0, pc_write},    32'd1);
        check("sf_if_id_write", {31'd0, if_id_write}, 32'd1);
        check("sf_id_jump",     {31'd0, id_Jump},     32'd0);
        step();
        flush = 1'b0;
        check("sf_ex_regdst", {30'd0, ex_RegDst},   32'd0);
        check("sf_ex_memrd",  {31'd0, ex_MemRead},  32'd0);
        check("sf_mem_memrd", {31'd0, mem_MemRead}, 32'd0);

        // jal decode and its trip to WB, followed by an unknown opcode.
        OpCode = 6'b000011; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        #1;
        check("jal_id_jump", {31'd0, id_Jump}, 32'd1);
        step();
        check("jal_ex_regdst", {30'd0, ex_RegDst}, 32'd2);
        OpCode = 6'b111111;
        #1;
        check("unk_id_jump", {31'd0, id_Jump}, 32'd0);
        step();
        check("unk_ex_regdst", {30'd0, ex_RegDst},  32'd0);
        check("unk_ex_aluop",  {29'd0, ex_ALUOp},   32'd0);
        check("unk_ex_alusrc", {31'd0, ex_ALUSrc},  32'd0);
        check("unk_ex_memrd",  {31'd0, ex_MemRead}, 32'd0);
        step();
        check("jal_wb_regwr",  {31'd0, wb_RegWrite},  32'd1);
        check("jal_wb_mtr",    {30'd0, wb_MemtoReg},  32'd2);
        check("unk_mem_memrd", {31'd0, mem_MemRead},  32'd0);
        check("unk_mem_memwr", {31'd0, mem_MemWrite}, 32'd0);
        check("unk_mem_br",    {31'd0, mem_Branch},   32'd0);
        check("unk_mem_brne",  {31'd0, mem_BranchNE}, 32'd0);
        step();
        check("unk_wb_regwr", {31'd0, wb_RegWrite}, 32'd0);
        check("unk_wb_mtr",   {30'd0, wb_MemtoReg}, 32'd0);

        // sw, ori, bne through EX and MEM.
        OpCode = 6'b101011;
        step();
        check("sw_ex_alusrc", {31'd0, ex_ALUSrc}, 32'd1);
        check("sw_ex_aluop",  {29'd0, ex_ALUOp},  32'd0);
        OpCode = 6'b001101;
        step();
        check("ori_ex_aluop", {29'd0, ex_ALUOp},     32'd4);
        check("sw_mem_memwr", {31'd0, mem_MemWrite}, 32'd1);
        OpCode = 6'b000101;
        step();
        check("bne_ex_aluop", {29'd0, ex_ALUOp}, 32'd1);
        OpCode = 6'b001010;
        step();
        check("slti_ex_aluop", {29'd0, ex_ALUOp},     32'd5);
        check("bne_mem_brne",  {31'd0, mem_BranchNE}, 32'd1);
        check("bne_mem_br",    {31'd0, mem_Branch},   32'd0);

        // Asynchronous reset in the middle of a cycle.
        OpCode = 6'b000000;
        step();
        step();
        check("ar_before_regdst", {30'd0, ex_RegDst},   32'd1);
        check("ar_before_wbregwr",{31'd0, wb_RegWrite}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_ex_regdst", {30'd0, ex_RegDst},   32'd0);
        check("ar_ex_aluop",  {29'd0, ex_ALUOp},    32'd0);
        check("ar_wb_regwr",  {31'd0, wb_RegWrite}, 32'd0);
        check("ar_pc_write",  {31'd0, pc_write},    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation control path for the 5-stage pipelined MIPS datapath.
- Decodes the ID-stage opcode into a control bundle, then carries it through ID/EX, EX/MEM and MEM/WB control registers.
- Emits stage-aligned control to each datapath stage.
- Adds load-use hazard stall, branch flush, a widened ALUOp and immediate/bne/jal support.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 3, ALUOp width; must be >= 3.
- REG_ADDR_W, 5, register-specifier width.
- LINK_REG, 31, destination register number for jal.

Ports:
- clk  input  1  pipeline clock; all registers update on rising edge.
- rst  input  1  asynchronous, active-low reset.
- OpCode  input  OPCODE_W  opcode of the instruction in IF/ID.
- id_rs  input  REG_ADDR_W  rs field of the IF/ID instruction.
- id_rt  input  REG_ADDR_W  rt field of the IF/ID instruction.
- ex_rt  input  REG_ADDR_W  rt field held in the ID/EX datapath register.
- flush  input  1  branch taken, resolved in MEM.
- pc_write  output  1  PC enable.
- if_id_write  output  1  IF/ID enable.
- id_Jump  output  1  jump redirect, j or jal, ID stage.
- ex_RegDst  output  2  destination select: 00 rt, 01 rd, 10 LINK_REG.
- ex_ALUSrc  output  1  1 selects the immediate operand.
- ex_ALUOp  output  ALUOP_W  ALU operation class.
- ex_MemRead  output  1  EX-stage copy, used for hazard detection.
- mem_MemRead  output  1  data-memory read.
- mem_MemWrite  output  1  data-memory write.
- mem_Branch  output  1  beq.
- mem_BranchNE  output  1  bne.
- wb_RegWrite  output  1  register-file write enable.
- wb_MemtoReg  output  2  writeback source: 00 ALU, 01 memory, 10 PC+4.

Behaviour:
- Decode (combinational, ID stage). Unlisted fields are 0.
  - 000000 R-type: RegDst=01, RegWrite, ALUOp=010.
  - 100011 lw: ALUSrc, MemRead, RegWrite, MemtoReg=01, ALUOp=000.
  - 101011 sw: ALUSrc, MemWrite, ALUOp=000.
  - 000100 beq: Branch, ALUOp=001.
  - 000101 bne: BranchNE, ALUOp=001.
  - 001000 addi: ALUSrc, RegWrite, ALUOp=000.
  - 001100 andi: ALUSrc, RegWrite, ALUOp=011.
  - 001101 ori: ALUSrc, RegWrite, ALUOp=100.
  - 001010 slti: ALUSrc, RegWrite, ALUOp=101.
  - 000010 j: Jump.
  - 000011 jal: Jump, RegWrite, RegDst=10, MemtoReg=10.
  - Any other opcode: all-zero bundle (NOP).
- ALUOp encodings are zero-extended to ALUOP_W.
- Hazard detection:
  - stall = ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - Both sources are compared for every opcode; this is conservative.
- Bubble = the all-zero bundle.
- Every clock edge:
  - ID/EX loads the bubble if (stall | flush), else the decoded bundle.
  - EX/MEM loads the bubble if flush, else ID/EX.
  - MEM/WB always loads EX/MEM. The instruction in MEM completes.
- pc_write = if_id_write = ~stall | flush. Flush has priority over stall.
- id_Jump = decoded Jump & ~stall & ~flush.
- Latency: a decoded field reaches its ex_ output 1 cycle after decode, mem_ after 2 cycles, wb_ after 3 cycles.
- Reset (rst=0, asynchronous): all three pipeline registers clear to the bubble, so all ex_/mem_/wb_ outputs are 0.
- Reset asserted mid-operation discards every in-flight bundle immediately, without waiting for clk.
- Release of reset is synchronous to the next clk edge.
- pc_write, if_id_write and id_Jump are combinational. During reset they follow the same equations with ex_MemRead=0, so pc_write=1 and if_id_write=1.
- Back-to-back lw→dependent→dependent stalls exactly 1 cycle per load-use pair; there is no repeat stall once the bubble is in EX.

Test Plan:
- Reset: hold rst=0 with OpCode=000000, toggle clk → every registered output is 0; pc_write=1. Release reset → ex_RegDst=01 and ex_ALUOp=010 after 1 edge; wb_RegWrite=1 after 3 edges.
- lw then add using rt: lw rt=5; next ID instruction has id_rs=5 → stall.
  - Expect pc_write=0 and if_id_write=0 for exactly 1 cycle.
  - Expect ex_ bundle = 0 on the following cycle, then the add's bundle.
- lw with ex_rt=0 matching id_rs=0 → no stall.
- beq in MEM with flush=1 while ID holds lw and EX holds addi:
  - Next cycle: ex_ and mem_ outputs are all 0.
  - wb_ shows the beq bundle: RegWrite=0.
- Simultaneous stall and flush → pc_write=1; ID/EX receives the bubble.
- jal decode: id_Jump=1 the same cycle. Three edges later wb_RegWrite=1 and wb_MemtoReg=10; ex_RegDst=10 was seen 2 cycles earlier.
- Unknown opcode 111111 → NOP bundle at every stage.
- Async reset asserted mid-clock with a bundle in flight → outputs drop to 0 without a clock edge.
